// File: rtl/quick_spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain, deserialises mosi
// into RX words and streams TX words onto miso, with valid-pulse handshakes.
module quick_spi_slave #(
    parameter int   DATA_WIDTH      = 16,
    parameter int   CPOL            = 0,
    parameter int   CPHA            = 0,
    parameter int   BITS_ORDER      = 1,
    parameter logic MISO_IDLE_VALUE = 1'b0,
    parameter int   COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sclk,
    input  logic                   ss_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_load,
    output logic [DATA_WIDTH-1:0]  rx_data,
    output logic                   rx_valid,
    output logic                   frame_active,
    output logic                   frame_end,
    output logic [COUNT_WIDTH-1:0] frame_bits
);

    localparam int   CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic CPOL_B = (CPOL != 0);

    typedef enum logic [1:0] {WAIT_DESELECT, IDLE, ACTIVE} state_t;

    state_t                  state;
    logic                    sclk_p0, sclk_p1, sclk_p2;
    logic                    ss_p0, ss_p1, ss_p2;
    logic                    mosi_p0, mosi_p1;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [CNT_W-1:0]        rx_cnt;
    logic [CNT_W-1:0]        tx_cnt;
    logic                    tx_first;
    logic                    lead_edge, trail_edge, sample_edge, shift_edge;
    logic                    ss_fall, ss_rise;
    logic [DATA_WIDTH-1:0]   tx_ordered;

    // The TX shift register always emits from its MSB, so LSB-first words are mirrored on load.
    function automatic logic [DATA_WIDTH-1:0] order_word(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++)
            r[i] = (BITS_ORDER != 0) ? w[i] : w[DATA_WIDTH-1-i];
        return r;
    endfunction

    // Synchroniser stages p0/p1, history p2 for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_p0 <= CPOL_B;
            sclk_p1 <= CPOL_B;
            sclk_p2 <= CPOL_B;
            ss_p0   <= 1'b0;
            ss_p1   <= 1'b0;
            ss_p2   <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            ss_p0   <= ss_n;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign lead_edge   = (sclk_p1 != CPOL_B) && (sclk_p2 == CPOL_B);
    assign trail_edge  = (sclk_p1 == CPOL_B) && (sclk_p2 != CPOL_B);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign ss_fall     = ss_p2 && !ss_p1;
    assign ss_rise     = !ss_p2 && ss_p1;
    assign tx_ordered  = order_word(tx_data);

    // Frame control, serialiser and deserialiser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_DESELECT;
            miso         <= MISO_IDLE_VALUE;
            miso_oe      <= 1'b0;
            tx_load      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            frame_bits   <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            tx_first     <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_end <= 1'b0;
            case (state)
                WAIT_DESELECT: begin
                    miso_oe      <= 1'b0;
                    miso         <= MISO_IDLE_VALUE;
                    frame_active <= 1'b0;
                    if (ss_p1)
                        state <= IDLE;
                end
                IDLE: begin
                    if (ss_fall) begin
                        if (enable) begin
                            tx_load      <= 1'b1;
                            tx_shift     <= tx_ordered;
                            miso         <= tx_ordered[DATA_WIDTH-1];
                            miso_oe      <= 1'b1;
                            frame_active <= 1'b1;
                            frame_bits   <= '0;
                            rx_cnt       <= '0;
                            tx_cnt       <= '0;
                            tx_first     <= (CPHA != 0);
                            state        <= ACTIVE;
                        end else begin
                            state <= WAIT_DESELECT;
                        end
                    end
                end
                ACTIVE: begin
                    if (rx_cnt == CNT_W'(DATA_WIDTH)) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        rx_cnt   <= '0;
                    end
                    if (ss_rise) begin
                        frame_end    <= 1'b1;
                        miso_oe      <= 1'b0;
                        miso         <= MISO_IDLE_VALUE;
                        frame_active <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        if (sample_edge) begin
                            if (BITS_ORDER != 0)
                                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_p1};
                            else
                                rx_shift <= {mosi_p1, rx_shift[DATA_WIDTH-1:1]};
                            rx_cnt <= (rx_cnt == CNT_W'(DATA_WIDTH)) ? CNT_W'(1) : rx_cnt + 1'b1;
                            if (frame_bits != '1)
                                frame_bits <= frame_bits + 1'b1;
                        end
                        if (shift_edge) begin
                            // Under CPHA=1 the first leading edge re-presents bit 0.
                            if (tx_first) begin
                                tx_first <= 1'b0;
                                miso     <= tx_shift[DATA_WIDTH-1];
                            end else if (tx_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                tx_load  <= 1'b1;
                                tx_shift <= tx_ordered;
                                miso     <= tx_ordered[DATA_WIDTH-1];
                                tx_cnt   <= '0;
                            end else begin
                                tx_shift <= tx_shift << 1;
                                miso     <= tx_shift[DATA_WIDTH-2];
                                tx_cnt   <= tx_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= WAIT_DESELECT;
            endcase
        end
    end

endmodule
